// File: rtl/tb_dina_map_if.sv
// Connects the systolic-array result stream to the tile-buffer port-A write path.
// The signal names match the surrounding codebase. The slave modport is the mapper's view.
interface tb_dina_map_if #(
  parameter int X              = 4,
  parameter int L              = 4,
  parameter int RSA_DW         = 32,
  parameter int TB_DINA_SEL_DW = 3
);
  logic [TB_DINA_SEL_DW-1:0] TB_dina_sel;
  logic                      l_k_0;
  logic                      start;
  logic                      C_valid;
  logic [X*RSA_DW-1:0]       C_dout;
  logic [L*RSA_DW-1:0]       TB_dina;
  logic [L-1:0]              TB_wea;
  logic                      busy;
  logic                      done;

  modport master (
    output TB_dina_sel, l_k_0, start, C_valid, C_dout,
    input  TB_dina, TB_wea, busy, done
  );

  modport slave (
    input  TB_dina_sel, l_k_0, start, C_valid, C_dout,
    output TB_dina, TB_wea, busy, done
  );
endinterface

// File: rtl/tb_dina_map.sv
// Maps systolic-array result lanes onto tile-buffer write lanes. Direct modes forward each beat.
// Cache modes capture a 2x2 block and re-emit it as a transfer, a transpose or a negated transpose.
module tb_dina_map #(
  parameter int X              = 4,
  parameter int L              = 4,
  parameter int RSA_DW         = 32,
  parameter int TB_DINA_SEL_DW = 3
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  tb_dina_map_if.slave      bus
);

  localparam int W = RSA_DW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAP0,
    S_CAP1,
    S_EMIT0,
    S_EMIT1
  } state_t;

  state_t         state, state_nxt;
  logic [L*W-1:0] dina_q, dina_nxt;
  logic [L-1:0]   wea_q, wea_nxt;
  logic           done_q, done_nxt;
  logic           accept, cap0, cap1;

  logic [1:0]     lat_mode;
  logic           lat_lk;
  logic [W-1:0]   m00, m01, m10, m11;
  logic [W-1:0]   e0a, e0b, e1a, e1b;
  logic [1:0]     sub;

  assign sub = bus.TB_dina_sel[1:0];

  // A pair of values lands on lanes 0,1 when lk is set, otherwise on lanes 2,3.
  function automatic logic [L*W-1:0] place_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic lk);
    logic [L*W-1:0] r;
    r = '0;
    if (lk) begin
      r[0*W +: W] = a;
      r[1*W +: W] = b;
    end else begin
      r[2*W +: W] = a;
      r[3*W +: W] = b;
    end
    return r;
  endfunction

  function automatic logic [L-1:0] pair_wea(input logic lk);
    logic [L-1:0] r;
    r = '0;
    if (lk) r[1:0] = 2'b11;
    else    r[3:2] = 2'b11;
    return r;
  endfunction

  // Emit beats from the captured block; the negation wraps at W bits.
  always_comb begin
    if (lat_mode == 2'b01) begin
      e0a = m00; e0b = m01;
      e1a = m10; e1b = m11;
    end else begin
      e0a = m00; e0b = m10;
      e1a = m01; e1b = m11;
    end
    if (lat_mode == 2'b11) begin
      e0a = -e0a; e0b = -e0b;
      e1a = -e1a; e1b = -e1b;
    end
  end

  // NOTE: every output of this block gets a default first, so no branch can infer a latch.
  always_comb begin
    state_nxt = state;
    dina_nxt  = '0;
    wea_nxt   = '0;
    done_nxt  = 1'b0;
    accept    = 1'b0;
    cap0      = 1'b0;
    cap1      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.TB_dina_sel[2]) begin
          if (bus.start && sub != 2'b00) begin
            accept    = 1'b1;
            state_nxt = S_CAP0;
          end
        end else if (bus.C_valid) begin
          case (sub)
            2'b01: begin
              for (int i = 0; i < L; i++)
                if (i < X) dina_nxt[i*W +: W] = bus.C_dout[i*W +: W];
              wea_nxt = '1;
            end
            2'b10: begin
              for (int i = 0; i < L; i++)
                if (i < X) dina_nxt[i*W +: W] = bus.C_dout[(X-1-i)*W +: W];
              wea_nxt = '1;
            end
            2'b11: begin
              dina_nxt = place_pair(bus.C_dout[0 +: W], bus.C_dout[W +: W], bus.l_k_0);
              wea_nxt  = pair_wea(bus.l_k_0);
            end
            default: ;
          endcase
        end
      end
      S_CAP0: if (bus.C_valid) begin
        cap0      = 1'b1;
        state_nxt = S_CAP1;
      end
      S_CAP1: if (bus.C_valid) begin
        cap1      = 1'b1;
        state_nxt = S_EMIT0;
      end
      S_EMIT0: begin
        dina_nxt  = place_pair(e0a, e0b, lat_lk);
        wea_nxt   = pair_wea(lat_lk);
        state_nxt = S_EMIT1;
      end
      S_EMIT1: begin
        dina_nxt  = place_pair(e1a, e1b, lat_lk);
        wea_nxt   = pair_wea(lat_lk);
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // NOTE: the captured block is reset too, so an aborted operation leaves no stale data behind.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dina_q   <= '0;
      wea_q    <= '0;
      done_q   <= 1'b0;
      lat_mode <= 2'b00;
      lat_lk   <= 1'b0;
      m00      <= '0;
      m01      <= '0;
      m10      <= '0;
      m11      <= '0;
    end else begin
      dina_q <= dina_nxt;
      wea_q  <= wea_nxt;
      done_q <= done_nxt;
      if (accept) begin
        lat_mode <= sub;
        lat_lk   <= bus.l_k_0;
      end
      if (cap0) begin
        m00 <= bus.C_dout[0 +: W];
        m01 <= bus.C_dout[W +: W];
      end
      if (cap1) begin
        m10 <= bus.C_dout[0 +: W];
        m11 <= bus.C_dout[W +: W];
      end
    end
  end

  assign bus.TB_dina = dina_q;
  assign bus.TB_wea  = wea_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state != S_IDLE);

endmodule

// File: tb/tb_tb_dina_map.sv
// Directed bench for tb_dina_map: a table of direct-mode vectors and hand-written cache-mode sequences.
module tb_tb_dina_map;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  tb_dina_map_if #(.X(4), .L(4), .RSA_DW(32), .TB_DINA_SEL_DW(3)) bus ();

  tb_dina_map #(.X(4), .L(4), .RSA_DW(32), .TB_DINA_SEL_DW(3)) dut (
    .clk       (clk),
    .sys_rst_n (rst_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [2:0]   sel;
    logic         lk;
    logic         cv;
    logic [127:0] c;
    logic [127:0] exp_dina;
    logic [3:0]   exp_wea;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [127:0] p4(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic lk, input logic st, input logic cv,
                       input logic [127:0] c);
    bus.TB_dina_sel = sel;
    bus.l_k_0       = lk;
    bus.start       = st;
    bus.C_valid     = cv;
    bus.C_dout      = c;
  endtask

  task automatic chk_out(input string name, input logic [127:0] dina, input logic [3:0] wea,
                         input logic busy, input logic done);
    check({name, ".dina"}, bus.TB_dina, dina);
    check({name, ".wea"},  {124'd0, bus.TB_wea}, {124'd0, wea});
    check({name, ".busy"}, {127'd0, bus.busy}, {127'd0, busy});
    check({name, ".done"}, {127'd0, bus.done}, {127'd0, done});
  endtask

  // Start a cache op, feed two beats, then check the two emitted writes and done.
  task automatic cache_op(input string name, input logic [2:0] sel, input logic lk,
                          input logic [31:0] a0, input logic [31:0] b0,
                          input logic [31:0] a1, input logic [31:0] b1,
                          input logic [127:0] w0, input logic [127:0] w1, input logic [3:0] wea);
    drive(sel, lk, 1'b1, 1'b0, '0);
    step();
    chk_out({name, ".acc"}, '0, 4'b0000, 1'b1, 1'b0);
    drive(sel, lk, 1'b0, 1'b1, p4(a0, b0, 32'd0, 32'd0));
    step();
    drive(sel, lk, 1'b0, 1'b1, p4(a1, b1, 32'd0, 32'd0));
    step();
    drive(sel, lk, 1'b0, 1'b0, '0);
    chk_out({name, ".cap"}, '0, 4'b0000, 1'b1, 1'b0);
    step();
    chk_out({name, ".w0"}, w0, wea, 1'b1, 1'b0);
    step();
    chk_out({name, ".w1"}, w1, wea, 1'b0, 1'b1);
  endtask

  initial begin
    vecs[0] = '{"pos",      3'b001, 1'b0, 1'b1, p4(1, 2, 3, 4),     p4(1, 2, 3, 4),     4'b1111};
    vecs[1] = '{"neg",      3'b010, 1'b0, 1'b1, p4(1, 2, 3, 4),     p4(4, 3, 2, 1),     4'b1111};
    vecs[2] = '{"new_lk1",  3'b011, 1'b1, 1'b1, p4(5, 6, 7, 8),     p4(5, 6, 0, 0),     4'b0011};
    vecs[3] = '{"new_lk0",  3'b011, 1'b0, 1'b1, p4(5, 6, 7, 8),     p4(0, 0, 5, 6),     4'b1100};
    vecs[4] = '{"idle_sub", 3'b000, 1'b1, 1'b1, p4(1, 2, 3, 4),     '0,                 4'b0000};
    vecs[5] = '{"no_valid", 3'b001, 1'b1, 1'b0, p4(1, 2, 3, 4),     '0,                 4'b0000};
    vecs[6] = '{"cache_ns", 3'b101, 1'b1, 1'b1, p4(1, 2, 3, 4),     '0,                 4'b0000};
    vecs[7] = '{"pos_sgn",  3'b001, 1'b0, 1'b1, p4(-1, 32'h8000_0000, 7, 0),
                                                p4(-1, 32'h8000_0000, 7, 0),        4'b1111};
    vecs[8] = '{"neg_b",    3'b010, 1'b1, 1'b1, p4(10, 20, 30, 40), p4(40, 30, 20, 10), 4'b1111};

    drive(3'b000, 1'b0, 1'b0, 1'b0, '0);
    #2;
    chk_out("reset", '0, 4'b0000, 1'b0, 1'b0);
    #10 rst_n = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].sel, vecs[k].lk, 1'b0, vecs[k].cv, vecs[k].c);
      step();
      check({vecs[k].name, ".dina"}, bus.TB_dina, vecs[k].exp_dina);
      check({vecs[k].name, ".wea"}, {124'd0, bus.TB_wea}, {124'd0, vecs[k].exp_wea});
    end

    // A registered write must vanish as soon as reset asserts, not at the next edge.
    drive(3'b001, 1'b0, 1'b0, 1'b1, p4(9, 9, 9, 9));
    step();
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", '0, 4'b0000, 1'b0, 1'b0);
    drive(3'b000, 1'b0, 1'b0, 1'b0, '0);
    #2 rst_n = 1'b1;
    step();

    cache_op("xpose", 3'b110, 1'b1, 1, 2, 3, 4, p4(1, 3, 0, 0), p4(2, 4, 0, 0), 4'b0011);
    step();
    chk_out("xpose.after", '0, 4'b0000, 1'b0, 1'b0);

    cache_op("negx", 3'b111, 1'b0, 1, -2, 32'h8000_0000, 4,
             p4(0, 0, -1, 32'h8000_0000), p4(0, 0, 2, -4), 4'b1100);
    // Back-to-back: start again while done is still high.
    cache_op("b2b_xfer", 3'b101, 1'b1, 9, 10, 11, 12, p4(9, 10, 0, 0), p4(11, 12, 0, 0), 4'b0011);
    step();
    chk_out("b2b.after", '0, 4'b0000, 1'b0, 1'b0);

    // Beat alongside the accepted start is dropped; sel, l_k_0 and start changes while busy are ignored.
    drive(3'b110, 1'b1, 1'b1, 1'b1, p4(100, 200, 0, 0));
    step();
    for (int g = 0; g < 3; g++) begin
      drive(3'b111, 1'b0, 1'b1, 1'b0, '0);
      step();
      chk_out($sformatf("gap%0d", g), '0, 4'b0000, 1'b1, 1'b0);
    end
    drive(3'b001, 1'b0, 1'b0, 1'b1, p4(1, 2, 0, 0));
    step();
    drive(3'b001, 1'b0, 1'b0, 1'b1, p4(3, 4, 0, 0));
    step();
    drive(3'b001, 1'b0, 1'b0, 1'b1, p4(50, 60, 70, 80));
    chk_out("gap.cap", '0, 4'b0000, 1'b1, 1'b0);
    step();
    chk_out("gap.w0", p4(1, 3, 0, 0), 4'b0011, 1'b1, 1'b0);
    step();
    chk_out("gap.w1", p4(2, 4, 0, 0), 4'b0011, 1'b0, 1'b1);
    step();
    chk_out("gap.direct", p4(50, 60, 70, 80), 4'b1111, 1'b0, 1'b0);
    drive(3'b000, 1'b0, 1'b0, 1'b0, '0);
    step();

    // Reset while in S_EMIT0 aborts the operation without writes or done.
    drive(3'b101, 1'b1, 1'b1, 1'b0, '0);
    step();
    drive(3'b101, 1'b1, 1'b0, 1'b1, p4(7, 8, 0, 0));
    step();
    drive(3'b101, 1'b1, 1'b0, 1'b1, p4(9, 10, 0, 0));
    step();
    drive(3'b000, 1'b0, 1'b0, 1'b0, '0);
    chk_out("pre_abort", '0, 4'b0000, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("abort", '0, 4'b0000, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      step();
      chk_out($sformatf("abort_hold%0d", r), '0, 4'b0000, 1'b0, 1'b0);
    end
    #2 rst_n = 1'b1;
    step();
    chk_out("abort_rel", '0, 4'b0000, 1'b0, 1'b0);
    cache_op("post_abort", 3'b110, 1'b0, 1, 2, 3, 4, p4(0, 0, 1, 3), p4(0, 0, 2, 4), 4'b1100);
    step();
    chk_out("post_abort.after", '0, 4'b0000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tb_dina_map.md
TB_DINA_MAP -- requirements
Module: tb_dina_map

Interface
REQ-001 SHALL have parameter X, default 4, number of systolic-array result lanes.
REQ-002 SHALL have parameter L, default 4, number of tile-buffer port-A lanes.
REQ-003 SHALL have parameter RSA_DW, default 32, lane data width (signed two's complement).
REQ-004 SHALL have parameter TB_DINA_SEL_DW, default 3, mode-select width.
REQ-005 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- sys_rst_n  in  1  reset; asynchronous, active-low.
- TB_dina_sel  in  TB_DINA_SEL_DW  bit[2]: 0 direct / 1 cache; bits[1:0]: sub-mode.
- l_k_0  in  1  lane-pair select for NEW and cache modes; 1: lanes 0,1; 0: lanes 2,3.
- start  in  1  one-cycle pulse that launches a cache operation.
- C_valid  in  1  C_dout beat valid.
- C_dout  in  X*RSA_DW  array result lanes; lane i is bits [i*RSA_DW +: RSA_DW].
- TB_dina  out  L*RSA_DW  registered tile-buffer write data.
- TB_wea  out  L  registered per-lane write enable.
- busy  out  1  high while a cache operation is in progress.
- done  out  1  one-cycle pulse when a cache operation completes.

Function
REQ-006 Direct mode (sel[2]=0, FSM in IDLE) SHALL register one write per C_valid beat, with 1-cycle latency.
REQ-007 Direct sub-modes SHALL be:
- 00 IDLE: wea=0, dina=0.
- 01 POS: dina lane i = C lane i; wea all ones.
- 10 NEG: dina lane i = C lane X-1-i; wea all ones.
- 11 NEW: C lanes 0,1 go to the l_k_0 lane pair; other lanes are 0; wea=0011 (l_k_0=1) or 1100 (l_k_0=0).
REQ-008 Any cycle with no write (C_valid=0, IDLE sub-mode, or cache mode with FSM in IDLE) SHALL drive TB_wea=0 and TB_dina=0.
REQ-009 Cache-mode FSM states SHALL be S_IDLE, S_CAP0, S_CAP1, S_EMIT0, S_EMIT1.
REQ-010 start SHALL be accepted only in S_IDLE with sel[2]=1 and sel[1:0]!=00; acceptance latches sel[1:0] and l_k_0 and moves the FSM to S_CAP0.
REQ-011 S_CAP0 SHALL wait for C_valid, capture m00=C0 and m01=C1, then go to S_CAP1.
REQ-012 S_CAP1 SHALL wait for C_valid, capture m10=C0 and m11=C1, then go to S_EMIT0.
REQ-013 S_EMIT0 SHALL write beat 0 and go to S_EMIT1; S_EMIT1 SHALL write beat 1, pulse done on the same edge, and return to S_IDLE.
REQ-014 Emitted data SHALL be placed on the latched lane pair, with wea as in REQ-007 NEW and the other lanes 0.
REQ-015 Emit patterns by latched sub-mode SHALL be:
- 01 transfer: (m00,m01) then (m10,m11).
- 10 transpose: (m00,m10) then (m01,m11).
- 11 negate-transpose: two's-complement negation of the transpose, truncated to RSA_DW, so -(-2^(RSA_DW-1)) wraps to itself.
REQ-016 busy SHALL be high in S_CAP0, S_CAP1, S_EMIT0 and S_EMIT1, and low in S_IDLE.
REQ-017 While busy, changes to TB_dina_sel and l_k_0 SHALL be ignored and the direct path SHALL not write.
REQ-018 start while busy SHALL be ignored.
REQ-019 C_valid in the same cycle that start is accepted SHALL not be captured.
REQ-020 C_valid during the EMIT states SHALL be dropped.
REQ-021 Latency from the capturing edge of beat 1 SHALL be: write 0 one cycle later, write 1 and done two cycles later.
REQ-022 A new start SHALL be accepted in the cycle after done, giving back-to-back operation with no gap.

Reset
REQ-023 While sys_rst_n=0, TB_dina, TB_wea, busy and done SHALL be 0, the FSM SHALL be S_IDLE, and captured registers SHALL be 0; this takes effect immediately and asynchronously.
REQ-024 Reset mid-operation SHALL abort the operation with no further writes and no done pulse.
REQ-025 After reset deassertion, the first edge SHALL behave as S_IDLE.

Verification
REQ-026 POS/NEG: sel=001 then 010, C lanes {1,2,3,4}, C_valid=1 -> next cycle dina={1,2,3,4} then {4,3,2,1}, wea=1111.
REQ-027 NEW: sel=011, C={5,6,x,x}; l_k_0=1 -> dina={5,6,0,0}, wea=0011; l_k_0=0 -> dina={0,0,5,6}, wea=1100.
REQ-028 Transpose: sel=110, l_k_0=1, start, then beats {1,2},{3,4} -> writes {1,3,0,0} and {2,4,0,0} on the 1st and 2nd cycles after beat 2, done coincident with the 2nd write, busy low next cycle.
REQ-029 Negate-transpose: sel=111, l_k_0=0, beats {1,-2},{0x80000000,4} -> writes {0,0,-1,0x80000000} and {0,0,2,-4}, wea=1100.
REQ-030 Start with C_valid in the same cycle, then a gap of 3 idle cycles before beats -> the first beat is not captured, the FSM waits, and the output is correct; sel toggled mid-operation has no effect.
REQ-031 Reset asserted in S_EMIT0 -> outputs 0 immediately, no done; the next start completes normally.
